// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory port.
//   lsu_state_e  - sequencer states (IDLE, ACCESS, WRITE, RESP)
//   F3_*         - RV32I load/store width/sign codes
//   f3_supported - 1 when a funct3 code is legal for the given direction
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores have no unsigned variants; loads accept all five codes.
   function automatic logic f3_supported(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte/half lane handling for the load/store port.
//   ld_word, ld_off, ld_funct3 -> ld_data : extract and sign/zero-extend a load
//   st_old, st_wdata, st_off, st_funct3 -> st_data : merge store data into a word
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_funct3,
   output logic [31:0] ld_data,
   input  logic [31:0] st_old,
   input  logic [31:0] st_wdata,
   input  logic [1:0]  st_off,
   input  logic [2:0]  st_funct3,
   output logic [31:0] st_data
);

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_W:    r = word;
         F3_BU:   r = {24'h0, b};
         F3_HU:   r = {16'h0, h};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] r;
      r = old;
      case (f3)
         F3_B: r[{off, 3'b000} +: 8] = wdata[7:0];
         F3_H: begin
            if (off[1]) r[31:16] = wdata[15:0];
            else        r[15:0]  = wdata[15:0];
         end
         F3_W:    r = wdata;
         default: r = old;
      endcase
      return r;
   endfunction

   assign ld_data = load_extract(ld_word, ld_off, ld_funct3);
   assign st_data = store_merge(st_old, st_wdata, st_off, st_funct3);

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator for a word-addressed
// data memory without byte enables. Sub-word stores are done as
// read-modify-write (ACCESS reads the old word, WRITE stores the merged word).
//   Request : req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata
//   Response: resp_valid (1-cycle pulse), resp_rdata, resp_fault
//   Memory  : mem_write_en, mem_addr (word aligned), mem_write_data, mem_read_data
// Build option: define LSU_MISALIGN_FAULT_EN to fault misaligned half/word
// accesses; otherwise the low address bits are simply truncated.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   lsu_state_e        state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              we_reg, we_next;
   logic [2:0]        f3_reg, f3_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [31:0]       old_reg, old_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              fault_reg, fault_next;
   logic              write_strobe;
   logic              req_misaligned;
   logic              req_fault;
   logic [31:0]       ld_data;
   logic [31:0]       st_data;
   logic [ADDR_W-1:0] word_addr;

`ifdef LSU_MISALIGN_FAULT_EN
   assign req_misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                         || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif

   assign req_fault = !f3_supported(req_we, req_funct3) || req_misaligned;
   assign word_addr = {addr_reg[ADDR_W-1:2], 2'b00};

   lsu_align u_align (
      .ld_word   (mem_read_data),
      .ld_off    (addr_reg[1:0]),
      .ld_funct3 (f3_reg),
      .ld_data   (ld_data),
      .st_old    (old_reg),
      .st_wdata  (wdata_reg),
      .st_off    (addr_reg[1:0]),
      .st_funct3 (f3_reg),
      .st_data   (st_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         f3_reg    <= 3'b000;
         wdata_reg <= 32'h0;
         old_reg   <= 32'h0;
         rdata_reg <= 32'h0;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         we_reg    <= we_next;
         f3_reg    <= f3_next;
         wdata_reg <= wdata_next;
         old_reg   <= old_next;
         rdata_reg <= rdata_next;
         fault_reg <= fault_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      we_next        = we_reg;
      f3_next        = f3_reg;
      wdata_next     = wdata_reg;
      old_next       = old_reg;
      rdata_next     = rdata_reg;
      fault_next     = fault_reg;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      write_strobe   = 1'b0;
      mem_addr       = '0;
      mem_write_data = 32'h0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_next  = req_addr;
               we_next    = req_we;
               f3_next    = req_funct3;
               wdata_next = req_wdata;
               rdata_next = 32'h0;
               fault_next = req_fault;
               // Faulting requests never touch memory.
               state_next = req_fault ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_addr = word_addr;
            if (!we_reg) begin
               rdata_next = ld_data;
               state_next = RESP;
            end else if (f3_reg == F3_W) begin
               write_strobe   = 1'b1;
               mem_write_data = wdata_reg;
               state_next     = RESP;
            end else begin
               old_next   = mem_read_data;
               state_next = WRITE;
            end
         end
         WRITE: begin
            mem_addr       = word_addr;
            write_strobe   = 1'b1;
            mem_write_data = st_data;
            state_next     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            rdata_next = 32'h0;
            fault_next = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Gating with rst guarantees an aborted read-modify-write leaves memory intact.
   assign mem_write_en = write_strobe && !rst;
   assign resp_rdata   = rdata_reg;
   assign resp_fault   = fault_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed self-checking bench for lsu_mem_port with a small
// word-addressed memory model (synchronous write, combinational read).
module tb_lsu_mem_port;
   import lsu_pkg::*;

   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic              mem_write_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   logic [31:0]       mem [0:15];
   logic              preload;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_addr[5:2]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[1] <= 32'h8899AABB;
      end else if (mem_write_en) begin
         mem[mem_addr[5:2]] <= mem_write_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one request, then watches up to 8 cycles after the accept edge.
   // Cycle 1 is the cycle right after the accept edge.
   task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int exp_writes, input int exp_wcyc);
      int lat;
      int writes;
      int wcyc;
      logic [31:0] rd;
      logic flt;
      lat = 0; writes = 0; wcyc = 0; rd = 32'h0; flt = 1'b0;
      check_eq({name, "_ready"}, {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      // Garbage on the request bus must be ignored after acceptance.
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_funct3 = 3'b111;
      for (int c = 1; c <= 8; c++) begin
         if (mem_write_en) begin
            writes++;
            wcyc = c;
            check_eq({name, "_waddr"}, mem_addr, {addr[31:2], 2'b00});
         end
         if (resp_valid) begin
            lat = c;
            rd  = resp_rdata;
            flt = resp_fault;
            break;
         end
         @(posedge clk); #1;
      end
      $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d rdata=%h fault=%0d writes=%0d",
               name, we, f3, addr, wd, lat, rd, flt, writes);
      check_eq({name, "_lat"}, lat, exp_lat);
      check_eq({name, "_rdata"}, rd, exp_rdata);
      check_eq({name, "_fault"}, {31'h0, flt}, {31'h0, exp_fault});
      check_eq({name, "_writes"}, writes, exp_writes);
      check_eq({name, "_wcyc"}, wcyc, exp_wcyc);
      @(posedge clk); #1;
   endtask

   initial begin
      int nresp;
      rst = 1'b1; preload = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
      check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check_eq("rst_rdata", resp_rdata, 32'h0);
      check_eq("rst_fault", {31'h0, resp_fault}, 32'h0);
      check_eq("rst_wen", {31'h0, mem_write_en}, 32'h0);
      check_eq("rst_maddr", mem_addr, 32'h0);
      check_eq("rst_wdata", mem_write_data, 32'h0);
      preload = 1'b0; rst = 1'b0;
      @(posedge clk); #1;

      //      name      we    f3     addr   wdata          lat rdata          flt wr wcyc
      run_req("lb7",    1'b0, F3_B,  32'h7, 32'h0,         2, 32'hFFFFFF88, 1'b0, 0, 0);
      run_req("lhu6",   1'b0, F3_HU, 32'h6, 32'h0,         2, 32'h00008899, 1'b0, 0, 0);
      run_req("lh4",    1'b0, F3_H,  32'h4, 32'h0,         2, 32'hFFFFAABB, 1'b0, 0, 0);
      run_req("lbu6",   1'b0, F3_BU, 32'h6, 32'h0,         2, 32'h00000099, 1'b0, 0, 0);
      run_req("lw4",    1'b0, F3_W,  32'h4, 32'h0,         2, 32'h8899AABB, 1'b0, 0, 0);
`ifdef LSU_MISALIGN_FAULT_EN
      run_req("lw6",    1'b0, F3_W,  32'h6, 32'h0,         1, 32'h0,        1'b1, 0, 0);
      run_req("lh5",    1'b0, F3_H,  32'h5, 32'h0,         1, 32'h0,        1'b1, 0, 0);
`else
      run_req("lw6",    1'b0, F3_W,  32'h6, 32'h0,         2, 32'h8899AABB, 1'b0, 0, 0);
      run_req("lh5",    1'b0, F3_H,  32'h5, 32'h0,         2, 32'hFFFFAABB, 1'b0, 0, 0);
`endif
      run_req("ld_f3x", 1'b0, 3'b011, 32'h4, 32'h0,        1, 32'h0,        1'b1, 0, 0);
      run_req("st_f3x", 1'b1, F3_BU, 32'h4, 32'h12345678,  1, 32'h0,        1'b1, 0, 0);
      check_eq("st_f3x_mem", mem[1], 32'h8899AABB);
      run_req("sb5",    1'b1, F3_B,  32'h5, 32'h00000123,  3, 32'h0,        1'b0, 1, 2);
      check_eq("sb5_mem", mem[1], 32'h889923BB);
      run_req("sw8",    1'b1, F3_W,  32'h8, 32'hDEADBEEF,  2, 32'h0,        1'b0, 1, 1);
      check_eq("sw8_mem", mem[2], 32'hDEADBEEF);
      run_req("shA",    1'b1, F3_H,  32'hA, 32'h5555CAFE,  3, 32'h0,        1'b0, 1, 2);
      check_eq("shA_mem", mem[2], 32'hCAFEBEEF);
`ifdef LSU_MISALIGN_FAULT_EN
      run_req("sw9",    1'b1, F3_W,  32'h9, 32'h11223344,  1, 32'h0,        1'b1, 0, 0);
      check_eq("sw9_mem", mem[2], 32'hCAFEBEEF);
`else
      run_req("sw9",    1'b1, F3_W,  32'h9, 32'h11223344,  2, 32'h0,        1'b0, 1, 1);
      check_eq("sw9_mem", mem[2], 32'h11223344);
`endif
      run_req("lb5",    1'b0, F3_B,  32'h5, 32'h0,         2, 32'h00000023, 1'b0, 0, 0);

      // SH aborted by reset during its WRITE cycle.
      check_eq("abort_ready0", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h4; req_wdata = 32'h0000FFFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("abort_acc_wen", {31'h0, mem_write_en}, 32'h0);
      @(posedge clk); #1;
      check_eq("abort_write_wen", {31'h0, mem_write_en}, 32'h1);
      rst = 1'b1;
      #1;
      check_eq("abort_wen_gated", {31'h0, mem_write_en}, 32'h0);
      @(posedge clk); #1;
      check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
      check_eq("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
      check_eq("abort_rdata", resp_rdata, 32'h0);
      check_eq("abort_fault", {31'h0, resp_fault}, 32'h0);
      check_eq("abort_wen", {31'h0, mem_write_en}, 32'h0);
      check_eq("abort_maddr", mem_addr, 32'h0);
      check_eq("abort_wdata", mem_write_data, 32'h0);
      rst = 1'b0;
      nresp = 0;
      repeat (4) begin
         if (resp_valid) nresp++;
         @(posedge clk); #1;
      end
      $display("txn abort_sh4 we=1 f3=%0d addr=00000004 -> responses=%0d mem1=%h", F3_H, nresp, mem[1]);
      check_eq("abort_noresp", nresp, 0);
      check_eq("abort_mem", mem[1], 32'h889923BB);
      run_req("lw4_post", 1'b0, F3_W, 32'h4, 32'h0,        2, 32'h889923BB, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
